memory_layer_node_reader: RTL
=============================

MEMORY_LAYER_NODE_READER -- requirements
Module: memory_layer_node_reader

Interface
REQ-001 Parameter NUM_CLASSES, default 16: number of class slots held by the node counter.
REQ-002 Parameter MAX_NODES, default 256: maximum nodes per class.
REQ-003 Parameter CLS_W, default $clog2(NUM_CLASSES): class index width.
REQ-004 Parameter NODE_W, default $clog2(MAX_NODES): node index width.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request to read out one class; sampled only in IDLE.
REQ-008 class_id  input  CLS_W  class to read, captured with start.
REQ-009 node_count  input  NODE_W+1  current node count of class_id from the node counter, captured with start.
REQ-010 out_ready  input  1  downstream accepts the current node index.
REQ-011 out_valid  output  1  out_class/out_node_idx/out_last are valid.
REQ-012 out_class  output  CLS_W  captured class index.
REQ-013 out_node_idx  output  NODE_W  node index being presented.
REQ-014 out_last  output  1  high with the final index of the class.
REQ-015 busy  output  1  high in STREAM and DONE.
REQ-016 done  output  1  one-cycle pulse at the end of a readout.
REQ-017 empty  output  1  high with done when the captured count was 0.
REQ-018 clamped  output  1  high with done when the captured count exceeded MAX_NODES.

Function
REQ-019 FSM states: IDLE, STREAM, DONE, encoded in a single state register.
REQ-020 IDLE with start=1 captures class_id and min(node_count, MAX_NODES) and sets clamped if node_count>MAX_NODES; if the clamped count is 0, go to DONE with empty=1, otherwise go to STREAM with idx=0.
REQ-021 start in STREAM or DONE is ignored and has no effect on any register.
REQ-022 In STREAM, out_valid=1, out_node_idx=idx, out_class=captured class, out_last=(idx==count-1).
REQ-023 Latency: start accepted at edge N gives out_valid=1 after edge N, presenting index 0.
REQ-024 Handshake: a transfer occurs on an edge where out_valid && out_ready; idx increments by 1 per transfer.
REQ-025 While out_valid && !out_ready, out_class, out_node_idx and out_last hold stable.
REQ-026 out_valid, once asserted, stays high until the transfer completes.
REQ-027 A transfer with out_last=1 moves to DONE; out_valid=0 in the following cycle.
REQ-028 Indices are emitted strictly 0..count-1 with no gaps or repeats; idx never wraps.
REQ-029 count==MAX_NODES emits indices 0..MAX_NODES-1; the counter is NODE_W+1 bits wide so it does not overflow.
REQ-030 DONE lasts exactly one cycle: done=1, empty/clamped reflect the readout, then return to IDLE.
REQ-031 empty and clamped are 0 whenever done=0.
REQ-032 busy=0 only in IDLE, so a new start is accepted the cycle after done.
REQ-033 node_count and class_id changing after capture do not affect the readout in progress.

Reset
REQ-034 rst=1 forces IDLE immediately, asynchronously, and clears every output: out_valid, out_last, busy, done, empty and clamped to 0, and out_class and out_node_idx to 0.
REQ-035 rst asserted mid-STREAM aborts the readout without a done pulse; after rst deasserts, the block waits for a new start.
REQ-036 start sampled on the first edge after rst deasserts is accepted normally.

Verification
REQ-037 start, class_id=3, node_count=4, out_ready=1 held -> indices 0,1,2,3 on four consecutive cycles, out_class=3, out_last only on index 3, then done=1 with empty=0.
REQ-038 node_count=5 with out_ready toggled 1,0,0,1,... -> outputs stable during stalls, exactly 5 transfers, no duplicates.
REQ-039 node_count=0 -> no out_valid, done=1 with empty=1 one cycle after start, busy high for that cycle.
REQ-040 node_count=MAX_NODES+3 -> exactly MAX_NODES transfers with the last index MAX_NODES-1, then done=1 with clamped=1.
REQ-041 Second start with class_id=7 during a class 2 readout -> ignored, all indices carry out_class=2.
REQ-042 rst pulsed after index 2 of count=8 -> outputs 0 immediately and no done; a fresh start with count=2 -> indices 0,1 then done.

Source files
------------

// File: rtl/memory_layer_node_reader.sv
// memory_layer_node_reader
//
// Reads out the node indices of one class. A start in IDLE captures the class
// index and its node count (clamped to MAX_NODES), then streams node indices
// 0..count-1 over a valid/ready output. It finishes with a one-cycle DONE state
// that reports whether the captured count was empty or clamped.
//
// Handshake: out_valid is high for the whole STREAM state. A transfer happens
// on a rising edge where out_valid && out_ready. While the output is stalled
// (out_valid && !out_ready), out_class, out_node_idx and out_last hold stable.
// out_valid only drops after the transfer that carries out_last.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           readout request, sampled only in IDLE
//   class_id        class to read, captured with start
//   node_count      node count of class_id, captured with start
//   out_ready       downstream accepts the presented index
//   out_valid       out_class / out_node_idx / out_last are valid
//   out_class       captured class index
//   out_node_idx    node index being presented
//   out_last        presented index is the final one of the class
//   busy            high in STREAM and DONE
//   done            one-cycle end-of-readout pulse
//   empty           with done: captured count was 0
//   clamped         with done: captured count exceeded MAX_NODES
//   dbg_state       current FSM state (0 IDLE, 1 STREAM, 2 DONE)
module memory_layer_node_reader #(
    parameter int NUM_CLASSES = 16,
    parameter int MAX_NODES   = 256,
    parameter int CLS_W       = $clog2(NUM_CLASSES),
    parameter int NODE_W      = $clog2(MAX_NODES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CLS_W-1:0]  class_id,
    input  logic [NODE_W:0]   node_count,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [CLS_W-1:0]  out_class,
    output logic [NODE_W-1:0] out_node_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              empty,
    output logic              clamped,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [NODE_W:0]   MAX_CNT = (NODE_W+1)'(MAX_NODES);
    localparam logic [NODE_W:0]   ONE_CNT = (NODE_W+1)'(1);
    localparam logic [NODE_W-1:0] ONE_IDX = NODE_W'(1);

    state_t              state_q,   state_d;
    logic [CLS_W-1:0]    class_q,   class_d;
    logic [NODE_W:0]     count_q,   count_d;
    logic [NODE_W-1:0]   idx_q,     idx_d;
    logic                empty_q,   empty_d;
    logic                clamped_q, clamped_d;

    logic                last_w;

    // count_q is at least 1 whenever we are in STREAM, so count_q-1 never
    // underflows where last_w matters.
    assign last_w = (state_q == ST_STREAM) && ({1'b0, idx_q} == (count_q - ONE_CNT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            class_q   <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            empty_q   <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            empty_q   <= empty_d;
            clamped_q <= clamped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        count_d   = count_q;
        idx_d     = idx_q;
        empty_d   = empty_q;
        clamped_d = clamped_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    class_d   = class_id;
                    idx_d     = '0;
                    empty_d   = (node_count == '0);
                    clamped_d = (node_count > MAX_CNT);
                    count_d   = (node_count > MAX_CNT) ? MAX_CNT : node_count;
                    state_d   = (node_count == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (out_ready) begin
                    // The final index is never incremented, so idx never wraps.
                    if (last_w) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + ONE_IDX;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_valid    = (state_q == ST_STREAM);
    assign out_class    = class_q;
    assign out_node_idx = idx_q;
    assign out_last     = last_w;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign empty        = (state_q == ST_DONE) && empty_q;
    assign clamped      = (state_q == ST_DONE) && clamped_q;
    assign dbg_state    = state_q;

endmodule
